honeybee_dispatch: RTL and testbench
====================================

Name: honeybee_dispatch

Overview:
- Sequencer that sits between the main controller and the honeybee collision accelerator.
- On a request it latches the six edge operands from the edge-collision register file and drives the accelerator start/done handshake.
- Bounds the wait with a watchdog and captures the 64-bit collision word.
- Presents the captured result as two 32-bit halves to the execute and memory stage muxes, with a one-cycle done pulse back to the controller.

Parameters:
- BUS_WIDTH, 32, width of each edge operand and of each result half.
- RESULT_WIDTH, 64, width of the accelerator return word; must equal 2*BUS_WIDTH.
- TIMEOUT_CYCLES, 1024, maximum cycles from launch to hb_done before abort; must be >= 2.
- TIMEOUT_W, $clog2(TIMEOUT_CYCLES), width of the watchdog counter.

Ports:
- clk  in  1  core clock.
- rstb  in  1  asynchronous active-low reset.
- req  in  1  start request from the main controller, level-sampled.
- e0..e5  in  BUS_WIDTH each  edge operands from the edge-collision register file.
- busy  out  1  high from the cycle after an accepted req until done.
- done  out  1  one-cycle completion pulse to the controller.
- timeout  out  1  sticky; set on watchdog abort, cleared by the next accepted req.
- hb_start  out  1  accelerator ap_start.
- hb_ready  in  1  accelerator ap_ready.
- hb_done  in  1  accelerator ap_done.
- hb_return  in  RESULT_WIDTH  accelerator ap_return.
- hb_e0..hb_e5  out  BUS_WIDTH each  latched operands driven to the accelerator.
- result_lo  out  BUS_WIDTH  captured result[BUS_WIDTH-1:0].
- result_hi  out  BUS_WIDTH  captured result[RESULT_WIDTH-1:BUS_WIDTH].
- result_valid  out  1  high once a result (or abort zero) is held; cleared by the next accepted req.

Behaviour:
- Reset (rstb low, async):
  - state=IDLE.
  - All outputs 0; operand latches 0; watchdog 0.
- States: IDLE, LAUNCH, WAIT, FINISH.
- IDLE:
  - req=1 latches e0..e5 into hb_e0..hb_e5 on that edge.
  - Clears timeout and result_valid, zeroes the watchdog, and moves to LAUNCH.
- LAUNCH:
  - hb_start=1, held until hb_ready=1 or hb_done=1 is sampled.
  - hb_ready=1 with hb_done=0 moves to WAIT.
  - hb_done=1 (with or without hb_ready) captures hb_return and moves to FINISH.
- WAIT:
  - hb_start=0.
  - hb_done=1 captures hb_return and moves to FINISH.
- Watchdog:
  - Increments every cycle spent in LAUNCH or WAIT.
  - If it equals TIMEOUT_CYCLES-1 and hb_done=0 in the same cycle, the block aborts: captured result is 0, timeout=1, move to FINISH.
  - hb_done in the same cycle as expiry wins; the result is captured and timeout stays 0.
- FINISH:
  - done=1 for exactly this cycle and result_valid=1.
  - Always returns to IDLE.
  - req here is ignored; it is accepted next cycle if still high.
- Latency (no abort):
  - Accepted req to done is 2 + N cycles, where N is the cycle count from hb_start rise to hb_done.
  - With hb_done on the first LAUNCH cycle, done follows req by exactly 2 cycles.
- Request and hold rules:
  - busy=1 in LAUNCH, WAIT and FINISH.
  - req while busy is dropped; there is no queuing.
  - Operand latches and result hold their values until the next accepted req; e0..e5 changing mid-operation has no effect.
- Stray hb_done in IDLE is ignored and does not disturb result or flags.
- Reset mid-operation drops everything immediately. The first req after reset starts cleanly even if the accelerator is still running; stale hb_done arriving in IDLE is ignored per the rule above.

Optional Feature:
- HB_RESULT_CACHE_EN defined:
  - Keeps a tag of the last operands that completed without abort, plus its result and a tag-valid bit.
  - Accepted req whose e0..e5 match a valid tag skips LAUNCH/WAIT: IDLE -> FINISH, done 1 cycle after req, hb_start never asserted.
  - Tag-valid clears on reset and on abort.
- Undefined: no tag storage; every request launches the accelerator.

Decomposition:
- Shared package honeybee_pkg holds:
  - the state enum type;
  - RESULT_WIDTH and the default TIMEOUT_CYCLES constants;
  - the six-operand edge struct, also reused by the edge register file.
- One sub-module, hb_watchdog: load/clear, count enable, and expired output at TIMEOUT_CYCLES-1.

Test Plan:
1. Basic handshake: req with e0..e5 = 1..6; hb_ready at the 2nd hb_start cycle; hb_done with hb_return=64'h0000_0001_0000_0002 three cycles later.
   - hb_start high exactly 2 cycles; hb_e* = 1..6.
   - done pulses once; result_hi=1, result_lo=2; timeout=0.
2. Zero-wait accelerator: hb_ready=hb_done=1 in the first LAUNCH cycle, hb_return=64'hFFFF_FFFF_0000_0000.
   - done exactly 2 cycles after req; result_hi=32'hFFFFFFFF, result_lo=0.
3. Timeout: TIMEOUT_CYCLES=8, hb_ready=1, hb_done never asserted.
   - done 9 cycles after req; timeout=1; result=0.
   - Next req clears timeout; hb_done on cycle 7 of that request gives timeout=0.
4. Busy drop and stray done:
   - req held high through an operation: exactly one launch per IDLE visit.
   - hb_done pulse in IDLE: result unchanged, no done pulse.
5. Async reset mid-WAIT: rstb low for 1 cycle, not aligned to clk.
   - All outputs 0 immediately; next req launches normally.
6. With HB_RESULT_CACHE_EN: repeat scenario 1's operands.
   - done 1 cycle after req; hb_start stays 0; same result.
   - Changing e3 forces a full launch.

Source files
------------

// File: rtl/honeybee_pkg.sv
// honeybee_pkg: shared state type, width/timeout constants and edge operand record
package honeybee_pkg;
  localparam int HB_BUS_WIDTH = 32;
  localparam int HB_RESULT_WIDTH = 64;
  localparam int HB_TIMEOUT_CYCLES = 1024;
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} hb_state_t;
  typedef struct packed {
    logic [HB_BUS_WIDTH-1:0] e5, e4, e3, e2, e1, e0;
  } hb_edge_t;
endpackage

// File: rtl/hb_watchdog.sv
// hb_watchdog: launch-to-done cycle counter, expired at TIMEOUT_CYCLES-1
module hb_watchdog
  import honeybee_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = HB_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic clk,
  input  logic rstb,
  input  logic clear,
  input  logic en,
  output logic expired
);
  logic [TIMEOUT_W-1:0] count;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) count <= '0;
    else if (clear) count <= '0;
    else if (en) count <= count + TIMEOUT_W'(1);
  assign expired = count == TIMEOUT_W'(TIMEOUT_CYCLES - 1);
endmodule

// File: rtl/honeybee_dispatch.sv
// honeybee_dispatch: start/done sequencer for the honeybee collision accelerator.
// Define HB_RESULT_CACHE_EN to replay the last clean result for repeated operands.
module honeybee_dispatch
  import honeybee_pkg::*;
#(
  parameter int BUS_WIDTH = HB_BUS_WIDTH,
  parameter int RESULT_WIDTH = HB_RESULT_WIDTH,
  parameter int TIMEOUT_CYCLES = HB_TIMEOUT_CYCLES,
  parameter int TIMEOUT_W = $clog2(TIMEOUT_CYCLES)
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    req,
  input  logic [BUS_WIDTH-1:0]    e0,
  input  logic [BUS_WIDTH-1:0]    e1,
  input  logic [BUS_WIDTH-1:0]    e2,
  input  logic [BUS_WIDTH-1:0]    e3,
  input  logic [BUS_WIDTH-1:0]    e4,
  input  logic [BUS_WIDTH-1:0]    e5,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout,
  output logic                    hb_start,
  input  logic                    hb_ready,
  input  logic                    hb_done,
  input  logic [RESULT_WIDTH-1:0] hb_return,
  output logic [BUS_WIDTH-1:0]    hb_e0,
  output logic [BUS_WIDTH-1:0]    hb_e1,
  output logic [BUS_WIDTH-1:0]    hb_e2,
  output logic [BUS_WIDTH-1:0]    hb_e3,
  output logic [BUS_WIDTH-1:0]    hb_e4,
  output logic [BUS_WIDTH-1:0]    hb_e5,
  output logic [BUS_WIDTH-1:0]    result_lo,
  output logic [BUS_WIDTH-1:0]    result_hi,
  output logic                    result_valid
);
  hb_state_t state, next;
  logic [5:0][BUS_WIDTH-1:0] ops, in_ops;
  logic [RESULT_WIDTH-1:0] res, hit_res;
  logic accept, active, capture, abort, expired, hit;
  assign in_ops = {e5, e4, e3, e2, e1, e0};
  assign active = state == LAUNCH || state == WAIT;
  assign accept = state == IDLE && req;
  assign capture = active && hb_done;
  assign abort = active && !hb_done && expired;
  hb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES), .TIMEOUT_W(TIMEOUT_W)) u_watchdog (
    .clk(clk), .rstb(rstb), .clear(accept), .en(active), .expired(expired)
  );
`ifdef HB_RESULT_CACHE_EN
  logic [5:0][BUS_WIDTH-1:0] tag;
  logic tag_valid;
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      tag <= '0;
      tag_valid <= 1'b0;
      hit_res <= '0;
    end else if (capture) begin
      tag <= ops;
      tag_valid <= 1'b1;
      hit_res <= hb_return;
    end else if (abort) tag_valid <= 1'b0;
  assign hit = tag_valid && tag == in_ops;
`else
  assign hit = 1'b0;
  assign hit_res = '0;
`endif
  always_comb begin
    next = state;
    unique case (state)
      IDLE:    next = !req ? IDLE : hit ? FINISH : LAUNCH;
      LAUNCH:  next = (capture || abort) ? FINISH : hb_ready ? WAIT : LAUNCH;
      WAIT:    next = (capture || abort) ? FINISH : WAIT;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      state <= IDLE;
      ops <= '0;
      res <= '0;
      timeout <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state <= next;
      if (accept) begin
        ops <= in_ops;
        timeout <= 1'b0;
        result_valid <= hit;
      end
      if (accept && hit) res <= hit_res;
      if (capture) res <= hb_return;
      if (abort) begin
        res <= '0;
        timeout <= 1'b1;
      end
      if (capture || abort) result_valid <= 1'b1;
    end
  assign busy = state != IDLE;
  assign done = state == FINISH;
  assign hb_start = state == LAUNCH;
  assign {hb_e5, hb_e4, hb_e3, hb_e2, hb_e1, hb_e0} = ops;
  assign result_lo = res[BUS_WIDTH-1:0];
  assign result_hi = res[RESULT_WIDTH-1:BUS_WIDTH];
endmodule

// File: tb/tb_honeybee_dispatch.sv
// tb_honeybee_dispatch: vector table, corner sequences and randomized ops against a transaction model
module tb_honeybee_dispatch;
  localparam int TO = 8;
  logic clk = 1'b0, rstb = 1'b0, req = 1'b0, hb_ready = 1'b0, hb_done = 1'b0;
  logic [5:0][31:0] e = '0;
  logic [63:0] hb_return = '0;
  logic busy, done, timeout, hb_start, result_valid;
  logic [31:0] hb_e0, hb_e1, hb_e2, hb_e3, hb_e4, hb_e5, result_lo, result_hi;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  honeybee_dispatch #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rstb(rstb), .req(req),
    .e0(e[0]), .e1(e[1]), .e2(e[2]), .e3(e[3]), .e4(e[4]), .e5(e[5]),
    .busy(busy), .done(done), .timeout(timeout), .hb_start(hb_start),
    .hb_ready(hb_ready), .hb_done(hb_done), .hb_return(hb_return),
    .hb_e0(hb_e0), .hb_e1(hb_e1), .hb_e2(hb_e2), .hb_e3(hb_e3), .hb_e4(hb_e4), .hb_e5(hb_e5),
    .result_lo(result_lo), .result_hi(result_hi), .result_valid(result_valid)
  );
  typedef struct {
    logic [5:0][31:0] ops;
    int r, d;
    logic [63:0] ret;
    int lat, st;
    logic to;
    logic [63:0] res;
  } vec_t;
  vec_t vt[7];
  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask
  function automatic logic [5:0][31:0] seq(input int b);
    logic [5:0][31:0] o;
    for (int i = 0; i < 6; i++) o[i] = 32'(b + i + 1);
    return o;
  endfunction
  // Transaction-level expectation: hb_ready at cycle r, hb_done at cycle d after launch (d >= TO never lands)
  function automatic void model(input int r, input int d, input logic [63:0] ret,
                                output int lat, output int st, output logic to, output logic [63:0] res);
    bit fin = d >= 0 && d < TO;
    int last = fin ? d : TO - 1;
    lat = fin ? d + 2 : TO + 1;
    st = (r < last ? r : last) + 1;
    to = !fin;
    res = fin ? ret : 64'h0;
  endfunction
  task automatic run(input logic [5:0][31:0] o, input int r, input int d, input logic [63:0] ret,
                     input int lat, input int st, input logic to, input logic [63:0] res, input string nm);
    int got = -1, starts = 0;
    e = o;
    req = 1'b1;
    hb_return = ret;
    @(negedge clk);
    req = 1'b0;
    chk({nm, " rv/to after accept"}, {result_valid, timeout}, {lat == 1, 1'b0});
    for (int k = 0; k < TO + 6; k++) begin
      if (done) begin
        got = k + 1;
        break;
      end
      starts += int'(hb_start);
      hb_ready = k == r;
      hb_done = k == d;
      e[k % 6] = $urandom;
      @(negedge clk);
    end
    hb_ready = 1'b0;
    hb_done = 1'b0;
    chk({nm, " latency"}, 192'(got), 192'(lat));
    chk({nm, " hb_start cycles"}, 192'(starts), 192'(st));
    chk({nm, " hb_e"}, {hb_e5, hb_e4, hb_e3, hb_e2, hb_e1, hb_e0}, o);
    chk({nm, " result/timeout/valid"}, {result_hi, result_lo, timeout, result_valid}, {res, to, 1'b1});
    @(negedge clk);
    chk({nm, " idle hold"}, {busy, done, result_hi, result_lo, result_valid}, {2'b00, res, 1'b1});
  endtask
  initial begin
    logic [5:0][31:0] o;
    int r, d, l, s;
    logic t;
    logic [63:0] ret, rs;
    vt[0] = '{seq(0),  1,  4, 64'h0000_0001_0000_0002, 6, 2, 1'b0, 64'h0000_0001_0000_0002};
    vt[1] = '{seq(10), 0,  0, 64'hFFFF_FFFF_0000_0000, 2, 1, 1'b0, 64'hFFFF_FFFF_0000_0000};
    vt[2] = '{seq(20), 0, -1, 64'h0000_0000_0000_1234, 9, 1, 1'b1, 64'h0};
    vt[3] = '{seq(30), 0,  6, 64'hAAAA_5555_0F0F_F0F0, 8, 1, 1'b0, 64'hAAAA_5555_0F0F_F0F0};
    vt[4] = '{seq(40), 2,  7, 64'h0123_4567_89AB_CDEF, 9, 3, 1'b0, 64'h0123_4567_89AB_CDEF};
    vt[5] = '{seq(50), 5, -1, 64'h0000_0000_0000_0077, 9, 6, 1'b1, 64'h0};
    vt[6] = '{seq(60), 3,  2, 64'h8000_0000_0000_0001, 4, 3, 1'b0, 64'h8000_0000_0000_0001};
    #12;
    chk("reset flags", {busy, done, timeout, hb_start, result_valid}, 0);
    chk("reset result", {result_hi, result_lo}, 0);
    chk("reset hb_e", {hb_e5, hb_e4, hb_e3, hb_e2, hb_e1, hb_e0}, 0);
    @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    foreach (vt[i]) run(vt[i].ops, vt[i].r, vt[i].d, vt[i].ret, vt[i].lat, vt[i].st, vt[i].to, vt[i].res, $sformatf("vec%0d", i));
    // req held high with an instant accelerator: LAUNCH, FINISH, IDLE repeating
    req = 1'b1;
    hb_ready = 1'b1;
    hb_done = 1'b1;
    hb_return = 64'hCAFE_F00D_1234_5678;
    for (int k = 0; k < 9; k++) begin
      e[0] = 32'(1000 + k);
      @(negedge clk);
      chk($sformatf("held req cycle %0d busy/start/done", k), {busy, hb_start, done}, {k % 3 != 2, k % 3 == 0, k % 3 == 1});
    end
    req = 1'b0;
    hb_ready = 1'b0;
    hb_done = 1'b0;
    @(negedge clk);
    hb_done = 1'b1;
    hb_return = 64'h9999_9999_9999_9999;
    @(negedge clk);
    hb_done = 1'b0;
    chk("stray done busy/done", {busy, done}, 0);
    @(negedge clk);
    chk("stray done result", {result_hi, result_lo, result_valid, timeout}, {64'hCAFE_F00D_1234_5678, 2'b10});
    e = seq(70);
    req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    hb_ready = 1'b1;
    @(negedge clk);
    hb_ready = 1'b0;
    @(negedge clk);
    chk("in wait before reset", {busy, hb_start, done}, 3'b100);
    #3 rstb = 1'b0;
    #1;
    chk("async reset flags", {busy, done, timeout, hb_start, result_valid}, 0);
    chk("async reset result", {result_hi, result_lo}, 0);
    chk("async reset hb_e", {hb_e5, hb_e4, hb_e3, hb_e2, hb_e1, hb_e0}, 0);
    #8 rstb = 1'b1;
    @(negedge clk);
    run(seq(80), 0, 1, 64'h0000_0042_0000_0024, 3, 1, 1'b0, 64'h0000_0042_0000_0024, "post reset");
`ifdef HB_RESULT_CACHE_EN
    run(seq(0), 1, 4, 64'h0000_0001_0000_0002, 6, 2, 1'b0, 64'h0000_0001_0000_0002, "cache fill");
    run(seq(0), 0, 0, 64'h0BAD_0BAD_0BAD_0BAD, 1, 0, 1'b0, 64'h0000_0001_0000_0002, "cache hit");
    o = seq(0);
    o[3] = 32'd99;
    run(o, 0, 0, 64'h0000_0055_0000_0055, 2, 1, 1'b0, 64'h0000_0055_0000_0055, "cache miss e3");
`endif
    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 6; j++) o[j] = $urandom;
      r = $urandom_range(0, 4);
      d = $urandom_range(0, TO + 1);
      ret = {$urandom, $urandom};
      model(r, d, ret, l, s, t, rs);
      run(o, r, d, ret, l, s, t, rs, $sformatf("rand%0d r%0d d%0d", i, r, d));
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
